// File: rtl/amba_axi_pkg.sv
// AXI4 field widths, burst/response encodings and channel bundles shared by AXI blocks.
package amba_axi_pkg;

    localparam int unsigned AXI_ID_W   = 4;
    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;
    localparam int unsigned AXI_LEN_W  = 8;
    localparam int unsigned AXI_SIZE_W = 3;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10,
        AXI_BURST_RSVD  = 2'b11
    } axi_burst_e;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_e;

    // Master-to-slave signals of all five channels.
    typedef struct packed {
        logic [AXI_ID_W-1:0]   awid;
        logic [AXI_ADDR_W-1:0] awaddr;
        logic [AXI_LEN_W-1:0]  awlen;
        logic [AXI_SIZE_W-1:0] awsize;
        axi_burst_e            awburst;
        logic                  awvalid;
        logic [AXI_DATA_W-1:0] wdata;
        logic [AXI_STRB_W-1:0] wstrb;
        logic                  wlast;
        logic                  wvalid;
        logic                  bready;
        logic [AXI_ID_W-1:0]   arid;
        logic [AXI_ADDR_W-1:0] araddr;
        logic [AXI_LEN_W-1:0]  arlen;
        logic [AXI_SIZE_W-1:0] arsize;
        axi_burst_e            arburst;
        logic                  arvalid;
        logic                  rready;
    } s_axi_mosi_t;

    // Slave-to-master signals of all five channels.
    typedef struct packed {
        logic                  awready;
        logic                  wready;
        logic [AXI_ID_W-1:0]   bid;
        axi_resp_e             bresp;
        logic                  bvalid;
        logic                  arready;
        logic [AXI_ID_W-1:0]   rid;
        logic [AXI_DATA_W-1:0] rdata;
        axi_resp_e             rresp;
        logic                  rlast;
        logic                  rvalid;
    } s_axi_miso_t;

endpackage

// File: rtl/dma_utils_pkg.sv
// DMA helper types: slave FSM states, captured request context, beat address helper.
package dma_utils_pkg;

    import amba_axi_pkg::*;

    localparam int unsigned BEAT_CNT_W = AXI_LEN_W + 1;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [AXI_LEN_W-1:0]  len;
        logic [AXI_SIZE_W-1:0] size;
        axi_burst_e            burst;
    } s_slv_ctx_t;

    // INCR advances by the transfer size (wrapping at 2^32); every other burst type stays on start.
    function automatic logic [AXI_ADDR_W-1:0] beat_addr(
        input logic [AXI_ADDR_W-1:0] start,
        input logic [BEAT_CNT_W-1:0] beat,
        input logic [AXI_SIZE_W-1:0] size,
        input axi_burst_e            burst
    );
        if (burst == AXI_BURST_INCR) begin
            return start + (AXI_ADDR_W'(beat) << size);
        end
        return start;
    endfunction

endpackage

// File: rtl/dma_ram_1w1r.sv
// Word-organised RAM: byte-masked synchronous write, combinational read (old data on same-cycle collision).
module dma_ram_1w1r #(
    parameter int unsigned WORDS  = 256,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_W-1:0]     rdata
);

    localparam int unsigned STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [WORDS];

    // Byte-lane write; storage is intentionally never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Asynchronous read port.
    assign rdata = mem[raddr];

endmodule

// File: rtl/dma_axi_slv_mem.sv
// AXI4 memory slave: independent write and read burst engines over a 1W1R byte-masked RAM.
module dma_axi_slv_mem
    import amba_axi_pkg::*;
    import dma_utils_pkg::*;
#(
    parameter int unsigned          MEM_WORDS = 256,
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  s_axi_mosi_t axi_mosi_i,
    output s_axi_miso_t axi_miso_o,
    output logic        busy_o
);

    localparam int unsigned IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned BYTE_SHIFT = $clog2(AXI_STRB_W);

    wr_state_e wstate_q, wstate_d;
    rd_state_e rstate_q, rstate_d;

    s_slv_ctx_t            wctx_q, rctx_q;
    logic [BEAT_CNT_W-1:0] wbeat_q;
    logic [AXI_LEN_W-1:0]  rbeat_q;
    logic                  wdec_q;
    axi_resp_e             bresp_q;

    logic awready_c, wready_c, bvalid_c, arready_c, rvalid_c, rlast_c;
    logic aw_hs, w_hs, ar_hs, r_hs;

    logic [AXI_ADDR_W-1:0] wr_addr, wr_off, rd_addr, rd_off;
    logic                  wr_oor, rd_oor, wr_len_bad;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic                  ram_we;
    logic [AXI_DATA_W-1:0] ram_rdata, rdata_c;
    axi_resp_e             rresp_c;

    // Current beat addresses, word indices and range decode for both directions.
    always_comb begin
        wr_addr    = beat_addr(wctx_q.addr, wbeat_q, wctx_q.size, wctx_q.burst);
        wr_off     = wr_addr - BASE_ADDR;
        wr_oor     = (wr_addr < BASE_ADDR) ||
                     ((wr_off >> BYTE_SHIFT) >= AXI_ADDR_W'(MEM_WORDS));
        wr_idx     = IDX_W'(wr_off >> BYTE_SHIFT);
        wr_len_bad = (wbeat_q != BEAT_CNT_W'(wctx_q.len));
        rd_addr    = beat_addr(rctx_q.addr, BEAT_CNT_W'(rbeat_q), rctx_q.size, rctx_q.burst);
        rd_off     = rd_addr - BASE_ADDR;
        rd_oor     = (rd_addr < BASE_ADDR) ||
                     ((rd_off >> BYTE_SHIFT) >= AXI_ADDR_W'(MEM_WORDS));
        rd_idx     = IDX_W'(rd_off >> BYTE_SHIFT);
    end

    // Write FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wstate_q <= W_IDLE;
        else      wstate_q <= wstate_d;
    end

    // Write FSM next state and channel handshakes.
    always_comb begin
        wstate_d  = wstate_q;
        awready_c = 1'b0;
        wready_c  = 1'b0;
        bvalid_c  = 1'b0;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        unique case (wstate_q)
            W_IDLE: begin
                awready_c = 1'b1;
                if (axi_mosi_i.awvalid) begin
                    aw_hs    = 1'b1;
                    wstate_d = W_DATA;
                end
            end
            W_DATA: begin
                wready_c = 1'b1;
                if (axi_mosi_i.wvalid) begin
                    w_hs = 1'b1;
                    if (axi_mosi_i.wlast) wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                bvalid_c = 1'b1;
                if (axi_mosi_i.bready) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Write request capture, beat counting and response accumulation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wctx_q  <= '0;
            wbeat_q <= '0;
            wdec_q  <= 1'b0;
            bresp_q <= AXI_RESP_OKAY;
        end else if (aw_hs) begin
            wctx_q  <= '{id: axi_mosi_i.awid, addr: axi_mosi_i.awaddr, len: axi_mosi_i.awlen,
                         size: axi_mosi_i.awsize, burst: axi_mosi_i.awburst};
            wbeat_q <= '0;
            wdec_q  <= 1'b0;
            bresp_q <= AXI_RESP_OKAY;
        end else if (w_hs) begin
            wbeat_q <= wbeat_q + BEAT_CNT_W'(1);
            wdec_q  <= wdec_q | wr_oor;
            if (axi_mosi_i.wlast) begin
                if (wdec_q || wr_oor)
                    bresp_q <= AXI_RESP_DECERR;
                else if (wr_len_bad || (wctx_q.burst == AXI_BURST_WRAP))
                    bresp_q <= AXI_RESP_SLVERR;
                else
                    bresp_q <= AXI_RESP_OKAY;
            end
        end
    end

    // WRAP bursts and out-of-range beats never touch storage.
    assign ram_we = w_hs && !wr_oor && (wctx_q.burst != AXI_BURST_WRAP);

    dma_ram_1w1r #(
        .WORDS  (MEM_WORDS),
        .DATA_W (AXI_DATA_W),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_idx),
        .wdata (axi_mosi_i.wdata),
        .wstrb (axi_mosi_i.wstrb),
        .raddr (rd_idx),
        .rdata (ram_rdata)
    );

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rstate_q <= R_IDLE;
        else      rstate_q <= rstate_d;
    end

    // Read FSM next state and channel handshakes.
    always_comb begin
        rstate_d  = rstate_q;
        arready_c = 1'b0;
        rvalid_c  = 1'b0;
        rlast_c   = 1'b0;
        ar_hs     = 1'b0;
        r_hs      = 1'b0;
        unique case (rstate_q)
            R_IDLE: begin
                arready_c = 1'b1;
                if (axi_mosi_i.arvalid) begin
                    ar_hs    = 1'b1;
                    rstate_d = R_DATA;
                end
            end
            R_DATA: begin
                rvalid_c = 1'b1;
                rlast_c  = (rbeat_q == rctx_q.len);
                if (axi_mosi_i.rready) begin
                    r_hs = 1'b1;
                    if (rlast_c) rstate_d = R_IDLE;
                end
            end
        endcase
    end

    // Read request capture and beat counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rctx_q  <= '0;
            rbeat_q <= '0;
        end else if (ar_hs) begin
            rctx_q  <= '{id: axi_mosi_i.arid, addr: axi_mosi_i.araddr, len: axi_mosi_i.arlen,
                         size: axi_mosi_i.arsize, burst: axi_mosi_i.arburst};
            rbeat_q <= '0;
        end else if (r_hs && !rlast_c) begin
            rbeat_q <= rbeat_q + AXI_LEN_W'(1);
        end
    end

    // Per-beat read response; errored beats return zero data.
    always_comb begin
        rresp_c = AXI_RESP_OKAY;
        rdata_c = ram_rdata;
        if (rd_oor) begin
            rresp_c = AXI_RESP_DECERR;
            rdata_c = '0;
        end else if (rctx_q.burst == AXI_BURST_WRAP) begin
            rresp_c = AXI_RESP_SLVERR;
            rdata_c = '0;
        end
    end

    // Response bundle assembly.
    always_comb begin
        axi_miso_o         = '0;
        axi_miso_o.awready = awready_c;
        axi_miso_o.wready  = wready_c;
        axi_miso_o.bvalid  = bvalid_c;
        axi_miso_o.bid     = wctx_q.id;
        axi_miso_o.bresp   = bresp_q;
        axi_miso_o.arready = arready_c;
        axi_miso_o.rvalid  = rvalid_c;
        axi_miso_o.rid     = rctx_q.id;
        axi_miso_o.rdata   = rdata_c;
        axi_miso_o.rresp   = rresp_c;
        axi_miso_o.rlast   = rlast_c;
    end

    assign busy_o = (wstate_q != W_IDLE) || (rstate_q != R_IDLE);

endmodule

// File: doc/dma_axi_slv_mem.md
DMA_AXI_SLV_MEM -- requirements
Module: dma_axi_slv_mem

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256: number of data-width words in the memory.
REQ-002 SHALL have parameter BASE_ADDR, default 0: byte address of word 0.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port axi_mosi_i, input, s_axi_mosi_t: AXI4 requests from the master.
REQ-006 SHALL have port axi_miso_o, output, s_axi_miso_t: AXI4 responses to the master.
REQ-007 SHALL have port busy_o, input-independent output, 1 bit: high while any read or write burst is in progress.

Function
REQ-008 SHALL have independent write FSM states W_IDLE, W_DATA and W_RESP, and read FSM states R_IDLE and R_DATA.
REQ-009 W_IDLE behaviour: awready=1; on awvalid&&awready, capture awid/awaddr/awlen/awsize/awburst, clear beat count and error flags, then go to W_DATA.
REQ-010 W_DATA behaviour: wready=1; each wvalid&&wready writes the strobed bytes (wstrb) at the current beat address; untouched bytes are unchanged.
REQ-011 W_DATA exit: on a wvalid&&wready beat with wlast=1, go to W_RESP; the burst ends on wlast even if the beat count != awlen.
REQ-012 W_RESP behaviour: bvalid=1 and bid=captured awid, held until bready; on bvalid&&bready go to W_IDLE.
REQ-013 bresp: DECERR if any beat was out of range; else SLVERR if the wlast beat count != awlen+1 or the burst was WRAP; else OKAY.
REQ-014 R_IDLE behaviour: arready=1; on arvalid&&arready, capture the AR fields, clear beat count, then go to R_DATA.
REQ-015 R_DATA behaviour: rvalid=1, rid=captured arid, rlast=(beat==arlen).
REQ-016 R_DATA data path: rdata is the memory word at the current beat address (combinational read); rdata, rresp and rlast are held stable until rready.
REQ-017 R_DATA advance: on rvalid&&rready, beat increments; on rlast beat, go to R_IDLE.
REQ-018 rresp is per beat: DECERR if that beat is out of range (rdata=0); SLVERR if arburst is WRAP (rdata=0, no access); else OKAY.
REQ-019 Beat address: INCR = start + beat*(1<<size), computed modulo the 32-bit address width; FIXED = start every beat.
REQ-020 Word index = (beat address - BASE_ADDR) >> log2(data bytes).
REQ-021 A beat is out of range when its address < BASE_ADDR or its word index >= MEM_WORDS; out-of-range writes are discarded.
REQ-022 Only one outstanding burst per direction: awready is 0 outside W_IDLE and arready is 0 outside R_IDLE.
REQ-023 On a simultaneous write commit and read of the same word in one cycle, the read returns the old data; the write is visible from the next cycle.
REQ-024 Write and read FSMs SHALL progress concurrently with no cross-channel stalls.
REQ-025 busy_o = (write FSM != W_IDLE) || (read FSM != R_IDLE).

Reset
REQ-026 On rst low, both FSMs SHALL enter IDLE asynchronously and all valid/ready outputs except awready and arready are 0.
REQ-027 awready=1 and arready=1 SHALL be asserted from the first cycle after reset release; beat counters and captured fields reset to 0.
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 Reset mid-burst SHALL abandon the burst with no response issued; bytes already written remain.

Structure
REQ-030 AXI types and encodings SHALL come from amba_axi_pkg.
REQ-031 The write/read FSM state enums and the s_slv_ctx_t captured-request struct SHALL be added to dma_utils_pkg.
REQ-032 Storage SHALL be one sub-module dma_ram_1w1r: one byte-masked synchronous write port and one combinational read port.

Verification
REQ-033 AW addr 0x10, len 3, size 2, INCR, wdata 1..4, wstrb 0xF -> bresp OKAY; AR addr 0x10 len 3 returns 1,2,3,4 with rlast on beat 3.
REQ-034 Write 0xAABBCCDD to 0x0, then write 0x11223344 with wstrb 0x3 to 0x0 -> read of 0x0 returns 0xAABB3344.
REQ-035 MEM_WORDS=256, 32-bit data, INCR len 1 write at 0x3FC -> beat 0 written, beat 1 discarded, bresp DECERR; read at 0x3FC len 1 -> rresp OKAY then DECERR with rdata 0.
REQ-036 AW len 3 with wlast on beat 2 -> bresp SLVERR and returns to W_IDLE; arburst WRAP -> every beat rresp SLVERR.
REQ-037 bready held low 5 cycles and rready toggled randomly -> bvalid, bid, rdata, rresp and rlast stay stable until handshake; awready/arready stay 0 meanwhile.
REQ-038 rst asserted during beat 2 of a len-7 write -> outputs reset immediately, no B response, next burst accepted normally.
